// File: rtl/dp_control_unit.sv
// Multi-cycle control unit for ARM-style data-processing instructions.
// Sequences FETCH/DECODE/EXEC/WB and owns the NZCV flag register.
module dp_control_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             halt,
    input  logic [31:0]      ir,
    input  logic             w_ir_valid,
    input  logic [3:0]       alu_nzcv,
    output logic             write_ir,
    output logic             write_pc,
    output logic [3:0]       nzcv,
    output logic [3:0]       rf_ra,
    output logic [3:0]       rf_rb,
    output logic [3:0]       rf_wa,
    output logic             rf_we,
    output logic [3:0]       alu_op,
    output logic             imm_sel,
    output logic [31:0]      imm32,
    output logic [1:0]       shift_type,
    output logic [4:0]       shift_num,
    output logic             illegal,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       state
);

    localparam logic [1:0] FETCH  = 2'd0;
    localparam logic [1:0] DECODE = 2'd1;
    localparam logic [1:0] EXEC   = 2'd2;
    localparam logic [1:0] WB     = 2'd3;

    logic        exec_ok;
    logic        is_cmp;
    logic        is_arith;
    logic        is_dp;
    logic [4:0]  rot;
    logic [63:0] imm_dbl;
    logic [63:0] imm_sh;
    logic        unused_ir;

    assign rf_ra      = ir[19:16];
    assign rf_rb      = ir[3:0];
    assign rf_wa      = ir[15:12];
    assign alu_op     = ir[24:21];
    assign imm_sel    = ir[25];
    assign shift_type = ir[6:5];
    assign shift_num  = ir[11:7];
    assign unused_ir  = ^ir[31:28];

    // Rotate-right done as a shift of the doubled word.
    assign rot     = {ir[11:8], 1'b0};
    assign imm_dbl = {24'd0, ir[7:0], 24'd0, ir[7:0]};
    assign imm_sh  = imm_dbl >> rot;
    assign imm32   = imm_sh[31:0];

    // TST/TEQ/CMP/CMN occupy opcodes 8..11.
    assign is_cmp   = (alu_op[3:2] == 2'b10);
    assign is_arith = (alu_op >= 4'd2 && alu_op <= 4'd7)
                    || alu_op == 4'd10 || alu_op == 4'd11;
    assign is_dp    = (ir[27:26] == 2'b00);

    // A fetch is issued in the first FETCH cycle when halt is
    // sampled low on entry; otherwise FETCH idles and re-samples halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            nzcv     <= 4'd0;
            retired  <= '0;
            rf_we    <= 1'b0;
            illegal  <= 1'b0;
            write_ir <= 1'b0;
            write_pc <= 1'b0;
            exec_ok  <= 1'b0;
        end else begin
            write_ir <= 1'b0;
            write_pc <= 1'b0;
            rf_we    <= 1'b0;
            illegal  <= 1'b0;
            unique case (state)
                FETCH: begin
                    if (write_ir) begin
                        exec_ok <= w_ir_valid;
                        state   <= DECODE;
                    end else if (!halt) begin
                        write_ir <= 1'b1;
                        write_pc <= 1'b1;
                    end
                end
                DECODE: begin
                    if (!exec_ok) begin
                        state    <= FETCH;
                        write_ir <= !halt;
                        write_pc <= !halt;
                    end else if (!is_dp) begin
                        illegal  <= 1'b1;
                        state    <= FETCH;
                        write_ir <= !halt;
                        write_pc <= !halt;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rf_we <= !is_cmp;
                    state <= WB;
                end
                WB: begin
                    if (ir[20]) begin
                        if (is_arith)
                            nzcv <= alu_nzcv;
                        else
                            nzcv <= {alu_nzcv[3:1], nzcv[0]};
                    end
                    retired  <= retired + 1'b1;
                    state    <= FETCH;
                    write_ir <= !halt;
                    write_pc <= !halt;
                end
            endcase
        end
    end

endmodule
